// File: rtl/rpn_pop_exec_if.sv
// Bundle between the RPN pop/execute unit and its owner: command/status signals plus
// the stack RAM port that the owner routes to this unit while busy is high.
interface rpn_pop_exec_if #(
  parameter int W  = 8,
  parameter int AW = 8
);
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] sp_in;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          mem_wren;
  logic [W-1:0]  mem_q;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] sp_out;
  logic          sp_load;
  logic [W-1:0]  result;
  logic          flag_z;
  logic          flag_c;

  modport master (
    output start, op, sp_in, mem_q,
    input  mem_addr, mem_wdata, mem_wren, busy, done, err,
           sp_out, sp_load, result, flag_z, flag_c
  );

  modport slave (
    input  start, op, sp_in, mem_q,
    output mem_addr, mem_wdata, mem_wren, busy, done, err,
           sp_out, sp_load, result, flag_z, flag_c
  );
endinterface

// File: rtl/rpn_pop_exec.sv
// RPN pop/execute unit: pops B (top) and A (next), computes A op B and writes the
// result back as the new top, then hands the decremented stack count to its owner.
module rpn_pop_exec #(
  parameter int W  = 8,
  parameter int AW = 8
) (
  input logic           CLOCK_50,
  input logic           RESET_N,
  rpn_pop_exec_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RD_B, WAIT_B, RD_A, WAIT_A, EXEC, WR, FIN, ERR
  } state_e;

  state_e        state_q;
  logic [2:0]    op_q;
  logic [AW-1:0] sp_q;
  logic [W-1:0]  b_q;
  logic [AW-1:0] mem_addr_q;
  logic [W-1:0]  mem_wdata_q;
  logic          mem_wren_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [AW-1:0] sp_out_q;
  logic          sp_load_q;
  logic [W-1:0]  result_q;
  logic          flag_z_q;
  logic          flag_c_q;

  logic [W:0]     sum_d;
  logic [2*W-1:0] prod_d;
  logic [W-1:0]   alu_res_d;
  logic           alu_c_d;

  // A is taken straight from mem_q during EXEC; B was captured in RD_A.
  always_comb begin
    sum_d     = {1'b0, bus.mem_q} + {1'b0, b_q};
    prod_d    = {{W{1'b0}}, bus.mem_q} * {{W{1'b0}}, b_q};
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    case (op_q)
      3'b000: begin
        alu_res_d = sum_d[W-1:0];
        alu_c_d   = sum_d[W];
      end
      3'b001: begin
        alu_res_d = bus.mem_q - b_q;
        alu_c_d   = (bus.mem_q < b_q);
      end
      3'b010: alu_res_d = bus.mem_q & b_q;
      3'b011: alu_res_d = bus.mem_q | b_q;
      3'b100: alu_res_d = bus.mem_q ^ b_q;
      3'b101: begin
        alu_res_d = prod_d[W-1:0];
        alu_c_d   = |prod_d[2*W-1:W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      op_q        <= '0;
      sp_q        <= '0;
      b_q         <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sp_out_q    <= '0;
      sp_load_q   <= 1'b0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sp_load_q  <= 1'b0;
      mem_wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            sp_q   <= bus.sp_in;
            busy_q <= 1'b1;
            if (bus.sp_in < AW'(2) || bus.op[2:1] == 2'b11) begin
              state_q <= ERR;
            end else begin
              mem_addr_q <= bus.sp_in - AW'(1);
              state_q    <= RD_B;
            end
          end
        end
        RD_B:   state_q <= WAIT_B;
        WAIT_B: begin
          mem_addr_q <= sp_q - AW'(2);
          state_q    <= RD_A;
        end
        RD_A: begin
          b_q     <= bus.mem_q;
          state_q <= WAIT_A;
        end
        WAIT_A: state_q <= EXEC;
        EXEC: begin
          result_q    <= alu_res_d;
          flag_z_q    <= (alu_res_d == '0);
          flag_c_q    <= alu_c_d;
          mem_wdata_q <= alu_res_d;
          mem_wren_q  <= 1'b1;
          state_q     <= WR;
        end
        WR: begin
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          sp_load_q <= 1'b1;
          sp_out_q  <= sp_q - AW'(1);
          state_q   <= FIN;
        end
        FIN: state_q <= IDLE;
        ERR: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wren  = mem_wren_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sp_out    = sp_out_q;
  assign bus.sp_load   = sp_load_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;

endmodule

// File: tb/tb_rpn_pop_exec.sv
// Directed bench for rpn_pop_exec: a 256x8 synchronous stack RAM shared between the
// bench preload port and the DUT (muxed on busy), with hand-computed expectations.
module tb_rpn_pop_exec;
  localparam int W  = 8;
  localparam int AW = 8;

  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  rpn_pop_exec_if #(.W(W), .AW(AW)) busIf ();

  rpn_pop_exec #(.W(W), .AW(AW)) dut (
    .CLOCK_50(clock),
    .RESET_N (resetN),
    .bus     (busIf)
  );

  logic [7:0] mem [256];
  logic [7:0] ramQ;
  logic [7:0] tbAddr;
  logic [7:0] tbWdata;
  logic       tbWren;
  logic [7:0] ramAddr;
  logic [7:0] ramWdata;
  logic       ramWren;

  assign ramAddr     = busIf.busy ? busIf.mem_addr  : tbAddr;
  assign ramWdata    = busIf.busy ? busIf.mem_wdata : tbWdata;
  assign ramWren     = busIf.busy ? busIf.mem_wren  : tbWren;
  assign busIf.mem_q = ramQ;

  always @(posedge clock) begin
    if (ramWren) mem[ramAddr] <= ramWdata;
    ramQ <= mem[ramAddr];
  end

  int         wrCount = 0;
  logic [7:0] lastWrAddr;
  logic [7:0] lastWrData;
  always @(posedge clock) begin
    if (busIf.mem_wren) begin
      wrCount    <= wrCount + 1;
      lastWrAddr <= busIf.mem_addr;
      lastWrData <= busIf.mem_wdata;
    end
  end

  int         testsRun = 0;
  int         testsFailed = 0;
  int         doneAt;
  int         doneCount;
  int         wrDelta;
  logic       errAtDone;
  logic       loadAtDone;
  logic [7:0] spOutAtDone;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic memWrite(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clock);
    tbAddr  = addr;
    tbWdata = data;
    tbWren  = 1'b1;
    @(negedge clock);
    tbWren  = 1'b0;
  endtask

  // Fixed 14-cycle observation window; k counts cycles after the accepting edge's start cycle.
  task automatic applyStimulus(input logic [2:0] opV, input logic [7:0] spV, input bit disturb);
    int wr0;
    @(negedge clock);
    busIf.op    = opV;
    busIf.sp_in = spV;
    busIf.start = 1'b1;
    wr0         = wrCount;
    doneAt      = 0;
    doneCount   = 0;
    errAtDone   = 1'b0;
    loadAtDone  = 1'b0;
    spOutAtDone = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (busIf.done) begin
        doneCount++;
        if (doneAt == 0) begin
          doneAt      = k;
          errAtDone   = busIf.err;
          loadAtDone  = busIf.sp_load;
          spOutAtDone = busIf.sp_out;
        end
      end
      busIf.start = 1'b0;
      if (disturb && k == 1) busIf.sp_in = 8'd3;
      if (disturb && k == 3) begin
        busIf.start = 1'b1;
        busIf.op    = 3'b001;
      end
    end
    wrDelta = wrCount - wr0;
  endtask

  task automatic checkOp(input string tag, input logic [7:0] expAddr, input logic [7:0] expData,
                         input logic [7:0] expSpOut, input logic expZ, input logic expC);
    checkOutput({tag, ".doneAt"},    doneAt,          7);
    checkOutput({tag, ".doneCount"}, doneCount,       1);
    checkOutput({tag, ".err"},       errAtDone,       0);
    checkOutput({tag, ".spLoad"},    loadAtDone,      1);
    checkOutput({tag, ".spOut"},     spOutAtDone,     expSpOut);
    checkOutput({tag, ".writes"},    wrDelta,         1);
    checkOutput({tag, ".wrAddr"},    lastWrAddr,      expAddr);
    checkOutput({tag, ".wrData"},    lastWrData,      expData);
    checkOutput({tag, ".ram"},       mem[expAddr],    expData);
    checkOutput({tag, ".result"},    busIf.result,    expData);
    checkOutput({tag, ".flagZ"},     busIf.flag_z,    expZ);
    checkOutput({tag, ".flagC"},     busIf.flag_c,    expC);
  endtask

  task automatic checkErr(input string tag, input logic [7:0] expResult,
                          input logic expZ, input logic expC);
    checkOutput({tag, ".doneAt"},    doneAt,       2);
    checkOutput({tag, ".doneCount"}, doneCount,    1);
    checkOutput({tag, ".err"},       errAtDone,    1);
    checkOutput({tag, ".spLoad"},    loadAtDone,   0);
    checkOutput({tag, ".writes"},    wrDelta,      0);
    checkOutput({tag, ".result"},    busIf.result, expResult);
    checkOutput({tag, ".flagZ"},     busIf.flag_z, expZ);
    checkOutput({tag, ".flagC"},     busIf.flag_c, expC);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".ramPort"}, {busIf.mem_addr, busIf.mem_wdata, busIf.mem_wren}, '0);
    checkOutput({tag, ".status"},
                {busIf.busy, busIf.done, busIf.err, busIf.sp_load, busIf.sp_out,
                 busIf.result, busIf.flag_z, busIf.flag_c}, '0);
  endtask

  initial begin
    int wr0;
    resetN      = 1'b0;
    busIf.start = 1'b0;
    busIf.op    = '0;
    busIf.sp_in = '0;
    tbAddr      = '0;
    tbWdata     = '0;
    tbWren      = 1'b0;
    repeat (2) @(negedge clock);
    checkResetState("reset");
    resetN = 1'b1;

    memWrite(8'd0, 8'd7);  memWrite(8'd1, 8'd5);
    applyStimulus(3'b000, 8'd2, 1'b0);
    checkOp("add", 8'd0, 8'd12, 8'd1, 1'b0, 1'b0);

    memWrite(8'd3, 8'd3);  memWrite(8'd4, 8'd9);
    applyStimulus(3'b001, 8'd5, 1'b0);
    checkOp("sub", 8'd3, 8'hFA, 8'd4, 1'b0, 1'b1);
    checkOutput("sub.topKept", mem[4], 8'd9);

    memWrite(8'd0, 8'd16); memWrite(8'd1, 8'd20);
    applyStimulus(3'b101, 8'd2, 1'b0);
    checkOp("mul", 8'd0, 8'd64, 8'd1, 1'b0, 1'b1);

    memWrite(8'd0, 8'h0F); memWrite(8'd1, 8'hF0);
    applyStimulus(3'b010, 8'd2, 1'b0);
    checkOp("and", 8'd0, 8'h00, 8'd1, 1'b1, 1'b0);

    memWrite(8'd0, 8'h3C); memWrite(8'd1, 8'h0F);
    applyStimulus(3'b100, 8'd2, 1'b0);
    checkOp("xor", 8'd0, 8'h33, 8'd1, 1'b0, 1'b0);

    memWrite(8'd0, 8'h3C); memWrite(8'd1, 8'h0F);
    applyStimulus(3'b011, 8'd2, 1'b0);
    checkOp("or", 8'd0, 8'h3F, 8'd1, 1'b0, 1'b0);

    memWrite(8'd0, 8'd200); memWrite(8'd1, 8'd100);
    applyStimulus(3'b000, 8'd2, 1'b0);
    checkOp("addCarry", 8'd0, 8'd44, 8'd1, 1'b0, 1'b1);

    // Rejected operations must leave the last result (44, carry set) untouched.
    applyStimulus(3'b000, 8'd1, 1'b0);
    checkErr("underflow", 8'd44, 1'b0, 1'b1);
    applyStimulus(3'b111, 8'd4, 1'b0);
    checkErr("reserved", 8'd44, 1'b0, 1'b1);
    applyStimulus(3'b000, 8'd0, 1'b0);
    checkErr("empty", 8'd44, 1'b0, 1'b1);

    memWrite(8'd253, 8'd10); memWrite(8'd254, 8'd4);
    applyStimulus(3'b001, 8'd255, 1'b0);
    checkOp("sp255", 8'd253, 8'd6, 8'd254, 1'b0, 1'b0);

    memWrite(8'd5, 8'd20); memWrite(8'd6, 8'd30);
    memWrite(8'd1, 8'd100); memWrite(8'd2, 8'd1);
    applyStimulus(3'b000, 8'd7, 1'b1);
    checkOp("ignore", 8'd5, 8'd50, 8'd6, 1'b0, 1'b0);
    checkOutput("ignore.mem1", mem[1], 8'd100);
    checkOutput("ignore.mem2", mem[2], 8'd1);

    memWrite(8'd0, 8'd1); memWrite(8'd1, 8'd2);
    @(negedge clock);
    wr0         = wrCount;
    busIf.op    = 3'b000;
    busIf.sp_in = 8'd2;
    busIf.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      busIf.start = 1'b0;
    end
    resetN = 1'b0;
    #1;
    checkResetState("midReset");
    repeat (3) @(negedge clock);
    checkOutput("midReset.writes", wrCount - wr0, 0);
    checkOutput("midReset.ram", mem[0], 8'd1);
    resetN = 1'b1;

    applyStimulus(3'b000, 8'd2, 1'b0);
    checkOp("afterReset", 8'd0, 8'd3, 8'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
